// File: rtl/camera_pkg.sv
// Shared types and constants for the camera readout path: FSM states, row tags
// and the width of one FIFO entry ({row, last, data}).
package camera_pkg;

   typedef enum logic [2:0] {
      IDLE,
      EXPOSING,
      ARMED,
      ROW1,
      ROW2
   } state_t;

   localparam logic ROW1_TAG = 1'b0;
   localparam logic ROW2_TAG = 1'b1;
   localparam int   TAG_W    = 2;

   function automatic int entry_width(input int data_w);
      return data_w + TAG_W;
   endfunction

endpackage

// File: rtl/readout_fifo.sv
// Synchronous show-ahead FIFO: the head entry is presented combinationally while
// non-empty. A push into a full FIFO is accepted only if a pop happens in the same cycle.
module readout_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int             AW       = $clog2(DEPTH);
   localparam logic [AW:0]    FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Masking the head while empty keeps the outputs at zero without resetting storage.
   assign head = empty ? '0 : mem[rd_ptr];

   // NOTE: the storage array is deliberately not reset; pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // NOTE: registers update with non-blocking assignments so every one sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/camera_readout.sv
// Receives two-row ADC frames driven by the camera controller strobes and streams tagged
// samples out of a FIFO. Optional macro CAMERA_READOUT_EXPTIME_EN adds the exp_cycles counter.
module camera_readout
   import camera_pkg::*;
#(
   parameter int DATA_W          = 8,
   parameter int SAMPLES_PER_ROW = 5,
   parameter int FIFO_DEPTH      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              erase,
   input  logic              expose,
   input  logic              nre1,
   input  logic              nre2,
   input  logic              adc,
   input  logic [DATA_W-1:0] adc_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_row,
   output logic              out_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              frame_done,
   output logic              proto_err,
   output logic              overflow
`ifdef CAMERA_READOUT_EXPTIME_EN
   ,
   output logic [5:0]        exp_cycles
`endif
);

   localparam int               ENTRY_W  = entry_width(DATA_W);
   localparam int               CNT_W    = $clog2(SAMPLES_PER_ROW + 1);
   localparam logic [CNT_W-1:0] FULL_ROW = SAMPLES_PER_ROW[CNT_W-1:0];
   localparam logic [CNT_W-1:0] LAST_IDX = FULL_ROW - 1'b1;

   state_t             state;
   logic [CNT_W-1:0]   row_cnt;
   logic               in_rows;
   logic               sample;
   logic               sample_r1;
   logic               sample_r2;
   logic               push;
   logic               row_tag;
   logic               last;
   logic               pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] head;

   assign in_rows   = (state == ARMED) || (state == ROW1) || (state == ROW2);
   assign sample    = adc & (nre1 ^ nre2) & in_rows;
   assign sample_r1 = sample & ~nre1;
   assign sample_r2 = sample & ~nre2;

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no latch can be inferred.
      push    = 1'b0;
      row_tag = ROW1_TAG;
      last    = 1'b0;
      if (!erase) begin
         unique case (state)
            ARMED: push = sample_r1;
            ROW1: begin
               if (sample_r1) begin
                  push = (row_cnt < FULL_ROW);
               end else if (sample_r2) begin
                  push    = 1'b1;
                  row_tag = ROW2_TAG;
                  last    = (SAMPLES_PER_ROW == 1);
               end
            end
            ROW2: begin
               if (sample_r2 && (row_cnt < FULL_ROW)) begin
                  push    = 1'b1;
                  row_tag = ROW2_TAG;
                  last    = (row_cnt == LAST_IDX);
               end
            end
            default: ;
         endcase
      end
   end

   assign pop       = out_valid & out_ready;
   assign out_valid = ~fifo_empty;
   assign {out_row, out_last, out_data} = head;

   readout_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data ({row_tag, last, adc_data}),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         row_cnt    <= '0;
         frame_done <= 1'b0;
         proto_err  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         overflow   <= push & fifo_full & ~pop;
         proto_err  <= (~nre1 & ~nre2) | (adc & ((state == IDLE) || (state == EXPOSING)));
         // An erase outside IDLE abandons the frame; already queued samples stay in the FIFO.
         if (erase && (state != IDLE)) begin
            state     <= IDLE;
            row_cnt   <= '0;
            proto_err <= 1'b1;
         end else begin
            unique case (state)
               IDLE:     if (expose) state <= EXPOSING;
               EXPOSING: if (!expose) state <= ARMED;
               ARMED: begin
                  if (sample_r1) begin
                     state   <= ROW1;
                     row_cnt <= CNT_W'(1);
                  end else if (sample_r2) begin
                     proto_err <= 1'b1;
                  end
               end
               ROW1: begin
                  if (sample_r1) begin
                     if (row_cnt < FULL_ROW) row_cnt <= row_cnt + 1'b1;
                     else proto_err <= 1'b1;
                  end else if (sample_r2) begin
                     state   <= ROW2;
                     row_cnt <= CNT_W'(1);
                     if (row_cnt != FULL_ROW) proto_err <= 1'b1;
                  end
               end
               ROW2: begin
                  if (sample_r2) begin
                     if (row_cnt < FULL_ROW) row_cnt <= row_cnt + 1'b1;
                     else proto_err <= 1'b1;
                  end else if (sample_r1) begin
                     proto_err <= 1'b1;
                  end else if (!adc && nre2) begin
                     state      <= IDLE;
                     row_cnt    <= '0;
                     frame_done <= 1'b1;
                     if (row_cnt != FULL_ROW) proto_err <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef CAMERA_READOUT_EXPTIME_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         exp_cycles <= '0;
      end else if ((state == IDLE) && expose) begin
         exp_cycles <= '0;
      end else if ((state == EXPOSING) && expose && (exp_cycles != 6'd63)) begin
         exp_cycles <= exp_cycles + 6'd1;
      end
   end
`endif

endmodule

// File: tb/tb_camera_readout.sv
// Randomized self-checking bench for camera_readout: a frame-level model predicts the
// output stream, pulse counts and (with CAMERA_READOUT_EXPTIME_EN) the exposure count.
module tb_camera_readout;

   localparam int DATA_W = 8;
   localparam int S      = 5;
   localparam int DEPTH  = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              erase = 1'b0;
   logic              expose = 1'b0;
   logic              nre1 = 1'b1;
   logic              nre2 = 1'b1;
   logic              adc = 1'b0;
   logic [DATA_W-1:0] adc_data = '0;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic              out_row;
   logic              out_last;
   logic              out_valid;
   logic              frame_done;
   logic              proto_err;
   logic              overflow;
`ifdef CAMERA_READOUT_EXPTIME_EN
   logic [5:0]        exp_cycles;
`endif

   camera_readout #(
      .DATA_W          (DATA_W),
      .SAMPLES_PER_ROW (S),
      .FIFO_DEPTH      (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .erase      (erase),
      .expose     (expose),
      .nre1       (nre1),
      .nre2       (nre2),
      .adc        (adc),
      .adc_data   (adc_data),
      .out_data   (out_data),
      .out_row    (out_row),
      .out_last   (out_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_done (frame_done),
      .proto_err  (proto_err),
      .overflow   (overflow)
`ifdef CAMERA_READOUT_EXPTIME_EN
      ,
      .exp_cycles (exp_cycles)
`endif
   );

   initial forever #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int exp_err, exp_done, exp_ovf, exp_pushed;
   int obs_err, obs_done, obs_ovf, obs_pops;
   int row_n;
   bit in_row2;
   bit rand_ready;
   bit hold_pending;
   logic [10:0] hold_val;
   logic [9:0]  exp_q [$];

   // Output monitor: checks every popped entry against the model and head stability.
   initial begin
      logic [9:0] exp_e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            hold_pending = 1'b0;
         end else begin
            if (frame_done) obs_done++;
            if (proto_err)  obs_err++;
            if (overflow)   obs_ovf++;
            if (hold_pending) begin
               vectors++;
               if ({out_valid, out_row, out_last, out_data} !== hold_val) begin
                  miscompares++;
                  $display("FAIL hold_stable: got %h expected %h",
                           {out_valid, out_row, out_last, out_data}, hold_val);
               end
            end
            hold_pending = out_valid && !out_ready;
            hold_val     = {out_valid, out_row, out_last, out_data};
            if (out_valid && out_ready) begin
               obs_pops++;
               vectors++;
               if (exp_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL unexpected_output: got %h expected none",
                           {out_row, out_last, out_data});
               end else begin
                  exp_e = exp_q.pop_front();
                  if ({out_row, out_last, out_data} !== exp_e) begin
                     miscompares++;
                     $display("FAIL stream_entry: got %h expected %h",
                              {out_row, out_last, out_data}, exp_e);
                  end
               end
            end
         end
      end
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input bit er, ex, n1, n2, a, input logic [7:0] d);
      erase    = er;
      expose   = ex;
      nre1     = n1;
      nre2     = n2;
      adc      = a;
      adc_data = d;
   endtask

   task automatic reset_model();
      exp_q.delete();
      exp_err = 0; exp_done = 0; exp_ovf = 0; exp_pushed = 0;
      obs_err = 0; obs_done = 0; obs_ovf = 0; obs_pops = 0;
      row_n = 0;
      in_row2 = 1'b0;
   endtask

   task automatic model_push(input bit row, input bit last, input logic [7:0] d);
      if (exp_q.size() >= DEPTH) exp_ovf++;
      else begin
         exp_q.push_back({row, last, d});
         exp_pushed++;
      end
   endtask

   task automatic do_expose(input int len);
      for (int i = 0; i < len; i++) begin
         set_in(0, 1, 1, 1, 0, 8'h00);
         step();
      end
      set_in(0, 0, 1, 1, 0, 8'h00);
      step();
      row_n   = 0;
      in_row2 = 1'b0;
`ifdef CAMERA_READOUT_EXPTIME_EN
      vectors++;
      if (exp_cycles !== 6'((len - 1 > 63) ? 63 : len - 1)) begin
         miscompares++;
         $display("FAIL exp_cycles: got %0d expected %0d", exp_cycles,
                  (len - 1 > 63) ? 63 : len - 1);
      end
`endif
   endtask

   task automatic do_row1(input int n, input bit fixed, input logic [7:0] base);
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) begin
            set_in(0, 0, 0, 1, 0, 8'h00);
            step();
         end
         d = fixed ? base + 8'(i) : 8'($urandom);
         set_in(0, 0, 0, 1, 1, d);
         if (row_n < S) begin
            row_n++;
            model_push(1'b0, 1'b0, d);
         end else exp_err++;
         step();
      end
      set_in(0, 0, 1, 1, 0, 8'h00);
      step();
   endtask

   task automatic do_row2(input int n, input bit fixed, input logic [7:0] base);
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) begin
            set_in(0, 0, 1, 0, 0, 8'h00);
            step();
         end
         d = fixed ? base + 8'(i) : 8'($urandom);
         set_in(0, 0, 1, 0, 1, d);
         if (!in_row2) begin
            if (row_n != S) exp_err++;
            in_row2 = 1'b1;
            row_n   = 0;
         end
         if (row_n < S) begin
            row_n++;
            model_push(1'b1, row_n == S, d);
         end else exp_err++;
         step();
      end
   endtask

   task automatic do_end();
      set_in(0, 0, 1, 1, 0, 8'h00);
      exp_done++;
      if (row_n != S) exp_err++;
      step();
      row_n   = 0;
      in_row2 = 1'b0;
      step();
   endtask

   task automatic drain(input string name);
      int n = 0;
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         step();
         n++;
      end
      vectors++;
      if (n >= 200) begin
         miscompares++;
         $display("FAIL %s_drain: got %0d entries left expected 0", name, exp_q.size());
      end
      step();
      step();
   endtask

   task automatic check_counts(input string name);
      vectors += 4;
      if (obs_err != exp_err) begin
         miscompares++;
         $display("FAIL %s_proto_err: got %0d pulses expected %0d", name, obs_err, exp_err);
      end
      if (obs_done != exp_done) begin
         miscompares++;
         $display("FAIL %s_frame_done: got %0d pulses expected %0d", name, obs_done, exp_done);
      end
      if (obs_ovf != exp_ovf) begin
         miscompares++;
         $display("FAIL %s_overflow: got %0d pulses expected %0d", name, obs_ovf, exp_ovf);
      end
      if (obs_pops != exp_pushed) begin
         miscompares++;
         $display("FAIL %s_pops: got %0d expected %0d", name, obs_pops, exp_pushed);
      end
      reset_model();
   endtask

   task automatic test_reset();
      reset_model();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      vectors += 3;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_valid: got %b expected 0", out_valid);
      end
      if ({out_row, out_last, out_data} !== 10'h000) begin
         miscompares++;
         $display("FAIL reset_data: got %h expected 000", {out_row, out_last, out_data});
      end
      if ({frame_done, proto_err, overflow} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_pulses: got %b expected 000", {frame_done, proto_err, overflow});
      end
`ifdef CAMERA_READOUT_EXPTIME_EN
      vectors++;
      if (exp_cycles !== 6'd0) begin
         miscompares++;
         $display("FAIL reset_exp_cycles: got %0d expected 0", exp_cycles);
      end
`endif
      @(negedge clk);
      reset = 1'b1;
      step();
   endtask

   task automatic test_nominal();
      out_ready = 1'b1;
      do_expose(15);
      do_row1(5, 1'b1, 8'h10);
      do_row2(5, 1'b1, 8'h20);
      do_end();
      drain("nominal");
      check_counts("nominal");
   endtask

   task automatic test_backpressure();
      logic [7:0] d;
      out_ready = 1'b0;
      do_expose(4);
      d = 8'($urandom);
      set_in(0, 0, 0, 1, 1, d);
      row_n = 1;
      model_push(1'b0, 1'b0, d);
      step();
      @(negedge clk);
      vectors += 2;
      if (out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL first_sample_valid: got %b expected 1", out_valid);
      end
      if ({out_row, out_last, out_data} !== {2'b00, d}) begin
         miscompares++;
         $display("FAIL first_sample_head: got %h expected %h",
                  {out_row, out_last, out_data}, {2'b00, d});
      end
      do_row1(4, 1'b0, 8'h00);
      do_row2(5, 1'b0, 8'h00);
      do_end();
      vectors += 2;
      if (obs_pops != 0) begin
         miscompares++;
         $display("FAIL backpressure_pops: got %0d expected 0", obs_pops);
      end
      if (out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL backpressure_valid: got %b expected 1", out_valid);
      end
      drain("backpressure");
      check_counts("backpressure");
   endtask

   task automatic test_overflow();
      out_ready = 1'b0;
      do_expose(3);
      do_row1(5, 1'b1, 8'h10);
      do_row2(5, 1'b1, 8'h20);
      do_end();
      do_expose(3);
      do_row1(5, 1'b1, 8'h30);
      do_row2(5, 1'b1, 8'h40);
      do_end();
      drain("overflow");
      check_counts("overflow");
   endtask

   task automatic test_short_row();
      out_ready = 1'b1;
      do_expose(5);
      do_row1(4, 1'b0, 8'h00);
      do_row2(5, 1'b0, 8'h00);
      do_end();
      drain("short_row");
      check_counts("short_row");
   endtask

   task automatic test_abort();
      out_ready = 1'b0;
      do_expose(3);
      do_row1(2, 1'b0, 8'h00);
      set_in(1, 0, 1, 1, 0, 8'h00);
      exp_err++;
      step();
      row_n = 0;
      set_in(0, 0, 1, 1, 0, 8'h00);
      step();
      // adc in IDLE flags an error only if the abort really returned to IDLE.
      set_in(0, 0, 1, 1, 1, 8'h00);
      exp_err++;
      step();
      set_in(0, 0, 1, 1, 0, 8'h00);
      step();
      vectors += 2;
      if (out_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL abort_kept: got %b expected 1", out_valid);
      end
      if (obs_pops != 0) begin
         miscompares++;
         $display("FAIL abort_pops: got %0d expected 0", obs_pops);
      end
      drain("abort");
      check_counts("abort");
   endtask

   task automatic test_misc_errors();
      out_ready = 1'b1;
      set_in(0, 0, 1, 1, 1, 8'h00);
      exp_err++;
      step();
      set_in(0, 0, 1, 1, 0, 8'h00);
      step();
      do_expose(3);
      set_in(0, 0, 1, 0, 1, 8'($urandom));
      exp_err++;
      step();
      set_in(0, 0, 0, 0, 0, 8'h00);
      exp_err++;
      step();
      set_in(0, 0, 1, 1, 0, 8'h00);
      step();
      do_row1(5, 1'b0, 8'h00);
      do_row2(2, 1'b0, 8'h00);
      set_in(0, 0, 0, 1, 1, 8'($urandom));
      exp_err++;
      step();
      do_row2(3, 1'b0, 8'h00);
      do_end();
      drain("misc");
      check_counts("misc");
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 6; f++) begin
         rand_ready = 1'b1;
         do_expose((f == 2) ? 70 : int'($urandom_range(2, 20)));
         do_row1($urandom_range(3, 7), 1'b0, 8'h00);
         do_row2($urandom_range(3, 7), 1'b0, 8'h00);
         do_end();
         drain("random");
      end
      check_counts("random");
   endtask

   task automatic test_reset_mid_frame();
      out_ready = 1'b0;
      do_expose(6);
      do_row1(5, 1'b0, 8'h00);
      do_row2(2, 1'b0, 8'h00);
      #2;
      reset = 1'b0;
      #1;
      vectors += 3;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL midreset_valid: got %b expected 0", out_valid);
      end
      if ({out_row, out_last, out_data} !== 10'h000) begin
         miscompares++;
         $display("FAIL midreset_data: got %h expected 000", {out_row, out_last, out_data});
      end
      if ({frame_done, proto_err, overflow} !== 3'b000) begin
         miscompares++;
         $display("FAIL midreset_pulses: got %b expected 000", {frame_done, proto_err, overflow});
      end
`ifdef CAMERA_READOUT_EXPTIME_EN
      vectors++;
      if (exp_cycles !== 6'd0) begin
         miscompares++;
         $display("FAIL midreset_exp_cycles: got %0d expected 0", exp_cycles);
      end
`endif
      reset_model();
      set_in(0, 0, 1, 1, 0, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      step();
      step();
      vectors++;
      if (out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL postreset_valid: got %b expected 0", out_valid);
      end
      out_ready = 1'b1;
      do_expose(8);
      do_row1(5, 1'b1, 8'h50);
      do_row2(5, 1'b1, 8'h60);
      do_end();
      drain("postreset");
      check_counts("postreset");
   endtask

   initial begin
      rand_ready = 1'b0;
      test_reset();
      test_nominal();
      test_backpressure();
      test_overflow();
      test_short_row();
      test_abort();
      test_misc_errors();
      test_random_frames();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
